// File: rtl/pair_detect_arbiter_if.sv
// Bundles the two requester handshakes and the result/status outputs of the
// shared equal-pair detector. The producer/consumer side uses 'master'; the
// arbiter uses 'slave'.
interface pair_detect_arbiter_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH / 2 + 1);

    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;

    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;

    logic             res_valid;
    logic             res_id;
    logic [CW-1:0]    res_count;
    logic             busy;

    modport master (
        output req0_valid, req0_data,
        input  req0_ready,
        output req1_valid, req1_data,
        input  req1_ready,
        input  res_valid, res_id, res_count, busy
    );

    modport slave (
        input  req0_valid, req0_data,
        output req0_ready,
        input  req1_valid, req1_data,
        output req1_ready,
        output res_valid, res_id, res_count, busy
    );
endinterface

// File: rtl/pair_detect_arbiter.sv
// Round-robin sharing of one bit-serial equal-pair detector between two
// word producers. A granted word is shifted MSB-first through a Mealy
// detector that flags non-overlapping "11"/"00" pairs; the match count is
// returned tagged with the owning requester.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | waiting for a request; ready driven to the granted requester
//  SHIFT | one word bit per cycle through the detector, MSB first
//  DONE  | res_valid pulse; result registers hold the finished count
//
//  det   | meaning
//  ------+-----------------------------------------------------------
//  D_S0  | no pending bit (start of word or right after a match)
//  D_L1  | previous unpaired bit was 1
//  D_L0  | previous unpaired bit was 0
module pair_detect_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    pair_detect_arbiter_if.slave bus
);
    localparam int CW = $clog2(WIDTH / 2 + 1);
    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        D_S0 = 2'd0,
        D_L1 = 2'd1,
        D_L0 = 2'd2
    } det_t;

    state_t           state;
    det_t             det;
    det_t             det_next;
    logic [WIDTH-1:0] shreg;
    logic [IW-1:0]    bit_idx;
    logic [CW-1:0]    match_cnt;
    logic [CW-1:0]    cnt_next;
    logic             last_grant;
    logic             cur_id;
    logic             grant0;
    logic             grant1;
    logic             cur_bit;
    logic             hit;

    // Round-robin grant: a lone requester always wins; with both valid the
    // one that was not served last wins. Reset leaves last_grant=1 so
    // requester 0 wins the first contested round.
    always_comb begin
        grant0 = bus.req0_valid & (~bus.req1_valid | last_grant);
        grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    end

    assign bus.req0_ready = (state == IDLE) & grant0;
    assign bus.req1_ready = (state == IDLE) & grant1;
    assign bus.busy       = (state != IDLE);

    // Mealy pair detector: the match for the current bit is seen in the
    // same cycle so the count never lags the shifted bit.
    always_comb begin
        cur_bit  = shreg[WIDTH-1];
        det_next = D_S0;
        hit      = 1'b0;
        unique case (det)
            D_S0: det_next = cur_bit ? D_L1 : D_L0;
            D_L1: begin
                if (cur_bit) hit      = 1'b1;
                else         det_next = D_L0;
            end
            D_L0: begin
                if (!cur_bit) hit      = 1'b1;
                else          det_next = D_L1;
            end
            default: det_next = D_S0;
        endcase
        cnt_next = match_cnt + CW'(hit);
    end

    // Control FSM, datapath registers and registered result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            det           <= D_S0;
            shreg         <= '0;
            bit_idx       <= '0;
            match_cnt     <= '0;
            last_grant    <= 1'b1;
            cur_id        <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_id    <= 1'b0;
            bus.res_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    bus.res_valid <= 1'b0;
                    if (grant0 || grant1) begin
                        shreg      <= grant1 ? bus.req1_data : bus.req0_data;
                        cur_id     <= grant1;
                        last_grant <= grant1;
                        match_cnt  <= '0;
                        det        <= D_S0;
                        bit_idx    <= IW'(WIDTH - 1);
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg     <= {shreg[WIDTH-2:0], 1'b0};
                    det       <= det_next;
                    match_cnt <= cnt_next;
                    if (bit_idx == '0) begin
                        // Last bit: publish the count including this bit's match.
                        state         <= DONE;
                        bus.res_valid <= 1'b1;
                        bus.res_id    <= cur_id;
                        bus.res_count <= cnt_next;
                    end else begin
                        bit_idx <= bit_idx - 1'b1;
                    end
                end
                DONE: begin
                    bus.res_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    bus.res_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pair_detect_arbiter.sv
// Directed bench for pair_detect_arbiter: single requests, pattern counts,
// round-robin alternation, back-to-back spacing, in-flight noise and abort.
module tb_pair_detect_arbiter;
    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH / 2 + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   hs_cyc  = 0;

    pair_detect_arbiter_if #(.WIDTH(WIDTH)) bus ();

    pair_detect_arbiter #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int id);
        return (id == 1) ? bus.req1_ready : bus.req0_ready;
    endfunction

    // Present a word from requester 'id', expect an immediate grant, then
    // follow it to its result. hold keeps valid asserted afterwards; poke
    // toggles requester 1 valid while the word is in flight.
    task automatic run_word(input int id, input logic [WIDTH-1:0] data, input int exp_cnt,
                            input bit hold, input bit poke, input string tag);
        int waited;
        int lat;
        if (id == 0) begin
            bus.req0_data  = data;
            bus.req0_valid = 1'b1;
        end else begin
            bus.req1_data  = data;
            bus.req1_valid = 1'b1;
        end
        #1;
        waited = 0;
        while (!rdy(id) && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, "_grant_wait"}, waited, 0);
        check({tag, "_ready"}, rdy(id), 1'b1);
        check({tag, "_other_ready"}, rdy(1 - id), 1'b0);
        tick();
        hs_cyc = cyc;
        if (!hold) begin
            if (id == 0) bus.req0_valid = 1'b0;
            else         bus.req1_valid = 1'b0;
        end
        check({tag, "_busy_shift"}, bus.busy, 1'b1);
        lat = 0;
        while (!bus.res_valid && lat < 20) begin
            if (poke) begin
                bus.req1_data  = 8'hFF;
                bus.req1_valid = lat[0];
                #1;
                check({tag, "_poke_ready"}, bus.req1_ready, 1'b0);
            end
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, WIDTH);
        if (poke) begin
            bus.req1_valid = 1'b1;
            #1;
            check({tag, "_poke_ready_done"}, bus.req1_ready, 1'b0);
            bus.req1_valid = 1'b0;
        end
        check({tag, "_busy_done"}, bus.busy, 1'b1);
        check({tag, "_id"}, bus.res_id, id);
        check({tag, "_count"}, bus.res_count, exp_cnt);
        tick();
        check({tag, "_valid_pulse"}, bus.res_valid, 1'b0);
        check({tag, "_busy_idle"}, bus.busy, 1'b0);
    endtask

    initial begin
        int prev_hs;
        bus.req0_valid = 1'b0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_data  = '0;

        // reset state
        repeat (3) tick();
        check("rst_res_valid", bus.res_valid, 1'b0);
        check("rst_res_id", bus.res_id, 1'b0);
        check("rst_res_count", bus.res_count, 0);
        check("rst_busy", bus.busy, 1'b0);
        #3 rst = 1'b1;
        tick();
        check("idle_ready0", bus.req0_ready, 1'b0);
        check("idle_ready1", bus.req1_ready, 1'b0);

        // single requests and pattern counts
        run_word(0, 8'hFF, 4, 1'b0, 1'b0, "t1_ff");
        run_word(1, 8'hAA, 0, 1'b0, 1'b0, "t2_aa");
        run_word(1, 8'hCC, 4, 1'b0, 1'b0, "t2_cc");
        run_word(1, 8'hE7, 3, 1'b0, 1'b0, "t2_e7");
        run_word(1, 8'h00, 4, 1'b0, 1'b0, "t2_00");

        // both valid and held: alternation resumes from last grant (1)
        bus.req0_data  = 8'hFF;
        bus.req1_data  = 8'hE7;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        run_word(0, 8'hFF, 4, 1'b1, 1'b0, "t3_g0");
        run_word(1, 8'hE7, 3, 1'b1, 1'b0, "t3_g1");
        run_word(0, 8'hFF, 4, 1'b1, 1'b0, "t3_g2");
        run_word(1, 8'hE7, 3, 1'b1, 1'b0, "t3_g3");
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();

        // back-to-back from requester 0 alone
        run_word(0, 8'hCC, 4, 1'b1, 1'b0, "t4_w0");
        prev_hs = hs_cyc;
        run_word(0, 8'hCC, 4, 1'b1, 1'b0, "t4_w1");
        check("t4_spacing1", hs_cyc - prev_hs, WIDTH + 2);
        prev_hs = hs_cyc;
        run_word(0, 8'hAA, 0, 1'b0, 1'b0, "t4_w2");
        check("t4_spacing2", hs_cyc - prev_hs, WIDTH + 2);
        tick();

        // requester 1 noise while a word is in flight
        run_word(0, 8'hE7, 3, 1'b0, 1'b0, "t6_pre");
        run_word(0, 8'hE7, 3, 1'b0, 1'b1, "t6_poke");
        tick();
        check("t6_no_grant_after", bus.busy, 1'b0);

        // abort mid-shift
        bus.req1_valid = 1'b0;
        bus.req0_data  = 8'hFF;
        bus.req0_valid = 1'b1;
        #1;
        check("t5_ready", bus.req0_ready, 1'b1);
        tick();
        bus.req0_valid = 1'b0;
        repeat (4) tick();
        check("t5_busy_before", bus.busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("t5_rst_valid", bus.res_valid, 1'b0);
        check("t5_rst_busy", bus.busy, 1'b0);
        check("t5_rst_count", bus.res_count, 0);
        check("t5_rst_id", bus.res_id, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("t5_no_valid", bus.res_valid, 1'b0);
        end
        #2 rst = 1'b1;
        bus.req1_data  = 8'h00;
        bus.req1_valid = 1'b1;
        run_word(0, 8'hFF, 4, 1'b0, 1'b0, "t5_after");
        bus.req1_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
